// File: rtl/abro_multi_fsm.sv
// Generalised ABRO controller: waits for every one of N event inputs, pulses o, then holds or re-arms.
// Latency: o/timeout/seen/state registered, 1 cycle from the completing input edge. No backpressure.
module abro_multi_fsm #(
    parameter int N          = 2,
    parameter int TIMEOUT    = 0,
    parameter int AUTO_REARM = 0,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r,
    input  logic [N-1:0]     in,
    output logic             o,
    output logic             timeout,
    output logic [N-1:0]     seen,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] done_count
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [N-1:0]     ALL     = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DONE    = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     seen_d;
    logic [N-1:0]     acc;
    logic [TW-1:0]    timer_q, timer_d;
    logic             o_d, timeout_d;
    logic [CNT_W-1:0] count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            seen       <= '0;
            timer_q    <= '0;
            o          <= 1'b0;
            timeout    <= 1'b0;
            done_count <= '0;
        end else begin
            state_q    <= state_d;
            seen       <= seen_d;
            timer_q    <= timer_d;
            o          <= o_d;
            timeout    <= timeout_d;
            done_count <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seen_d    = seen;
        timer_d   = timer_q;
        o_d       = 1'b0;
        timeout_d = 1'b0;
        acc       = seen | in;

        if (r) begin
            state_d = IDLE;
            seen_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in == ALL) begin
                        seen_d  = ALL;
                        o_d     = 1'b1;
                        state_d = DONE;
                    end else if (in != '0) begin
                        seen_d  = in;
                        timer_d = '0;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    seen_d = acc;
                    // Completion is tested first so it beats a timeout on the same edge.
                    if (acc == ALL) begin
                        o_d     = 1'b1;
                        state_d = DONE;
                    end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                        timeout_d = 1'b1;
                        seen_d    = '0;
                        timer_d   = '0;
                        state_d   = IDLE;
                    end else if (TIMEOUT != 0) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DONE: begin
                    seen_d = ALL;
                    if (AUTO_REARM != 0) begin
                        seen_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    seen_d  = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end
            endcase
        end

        count_d = done_count;
        if (o_d && (done_count != CNT_MAX)) begin
            count_d = done_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_abro_multi_fsm.sv
// Bench: three configurations share stimulus; a phase-level model is checked every cycle, plus literal expectations.
module tb_abro_multi_fsm;

    localparam int P_T   [3] = '{0, 4, 0};
    localparam int P_AR  [3] = '{0, 0, 1};
    localparam int P_MAX [3] = '{15, 15, 3};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r = 1'b0;
    logic [2:0] in_v = 3'b000;

    logic [2:0]      o_w, to_w;
    logic [2:0][2:0] seen_w;
    logic [2:0][1:0] st_w;
    logic [3:0]      cnt_a, cnt_b;
    logic [1:0]      cnt_c;

    int checks = 0;
    int failures = 0;

    // model state: phase 0 idle, 1 collecting, 2 done; el counts collect edges since entry
    int m_ph [3], m_seen [3], m_el [3], m_o [3], m_to [3], m_cnt [3];

    always #5 clk = ~clk;

    abro_multi_fsm #(.N(3), .TIMEOUT(0), .AUTO_REARM(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .r(r), .in(in_v), .o(o_w[0]), .timeout(to_w[0]),
        .seen(seen_w[0]), .state(st_w[0]), .done_count(cnt_a));
    abro_multi_fsm #(.N(3), .TIMEOUT(4), .AUTO_REARM(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .r(r), .in(in_v), .o(o_w[1]), .timeout(to_w[1]),
        .seen(seen_w[1]), .state(st_w[1]), .done_count(cnt_b));
    abro_multi_fsm #(.N(3), .TIMEOUT(0), .AUTO_REARM(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .r(r), .in(in_v), .o(o_w[2]), .timeout(to_w[2]),
        .seen(seen_w[2]), .state(st_w[2]), .done_count(cnt_c));

    function automatic int cnt_of(input int k);
        if (k == 0) return int'(cnt_a);
        if (k == 1) return int'(cnt_b);
        return int'(cnt_c);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_ph[k] <= 0; m_seen[k] <= 0; m_el[k] <= 0;
                m_o[k] <= 0; m_to[k] <= 0; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int ph, sd, el, o, to, c;
                ph = m_ph[k]; sd = m_seen[k]; el = m_el[k]; c = m_cnt[k];
                o = 0; to = 0;
                if (r) begin
                    ph = 0; sd = 0; el = 0;
                end else if (ph == 0) begin
                    if (in_v == 3'b111) begin
                        sd = 7; o = 1; ph = 2;
                    end else if (in_v != 3'b000) begin
                        sd = int'(in_v); el = 0; ph = 1;
                    end
                end else if (ph == 1) begin
                    sd = sd | int'(in_v);
                    el = el + 1;
                    if (sd == 7) begin
                        o = 1; ph = 2;
                    end else if (P_T[k] != 0 && el == P_T[k]) begin
                        to = 1; sd = 0; ph = 0;
                    end
                end else if (P_AR[k] != 0) begin
                    ph = 0; sd = 0;
                end
                if (o == 1 && c < P_MAX[k]) c = c + 1;
                m_ph[k] <= ph; m_seen[k] <= sd; m_el[k] <= el;
                m_o[k] <= o; m_to[k] <= to; m_cnt[k] <= c;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_state[%0d]", k), int'(st_w[k]), m_ph[k]);
                chk($sformatf("model_seen[%0d]", k), int'(seen_w[k]), m_seen[k]);
                chk($sformatf("model_o[%0d]", k), int'(o_w[k]), m_o[k]);
                chk($sformatf("model_timeout[%0d]", k), int'(to_w[k]), m_to[k]);
                chk($sformatf("model_count[%0d]", k), cnt_of(k), m_cnt[k]);
            end
        end
    end

    task automatic step(input logic [2:0] i, input logic rr);
        in_v = i;
        r = rr;
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_o[%0d]", tag, k), int'(o_w[k]), 0);
            chk($sformatf("%s_to[%0d]", tag, k), int'(to_w[k]), 0);
            chk($sformatf("%s_seen[%0d]", tag, k), int'(seen_w[k]), 0);
            chk($sformatf("%s_state[%0d]", tag, k), int'(st_w[k]), 0);
            chk($sformatf("%s_cnt[%0d]", tag, k), cnt_of(k), 0);
        end
    endtask

    task automatic pulse_reset();
        in_v = 3'b000;
        r = 1'b0;
        #2 reset_n = 1'b0;
        #1 all_zero("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1 all_zero("rst_init");
        @(negedge clk);
        reset_n = 1'b1;

        // in-order-independent collection
        step(3'b001, 1'b0);
        chk("a_seen1", int'(seen_w[0]), 1); chk("a_state1", int'(st_w[0]), 1);
        step(3'b100, 1'b0);
        chk("a_seen2", int'(seen_w[0]), 5); chk("a_state2", int'(st_w[0]), 1);
        step(3'b010, 1'b0);
        chk("a_seen3", int'(seen_w[0]), 7); chk("a_state3", int'(st_w[0]), 2);
        chk("a_o3", int'(o_w[0]), 1); chk("a_cnt3", int'(cnt_a), 1);
        for (int j = 0; j < 5; j++) begin
            step(3'b111, 1'b0);
            chk("a_hold_o", int'(o_w[0]), 0);
        end
        chk("a_hold_state", int'(st_w[0]), 2);
        step(3'b000, 1'b1);
        chk("a_r_state", int'(st_w[0]), 0); chk("a_r_seen", int'(seen_w[0]), 0);
        chk("a_r_cnt", int'(cnt_a), 1);

        // all bits at once from IDLE
        step(3'b111, 1'b0);
        chk("a_all_o", int'(o_w[0]), 1); chk("a_all_state", int'(st_w[0]), 2);
        chk("a_all_cnt", int'(cnt_a), 2);
        step(3'b000, 1'b1);

        // timeout after TIMEOUT collect edges
        step(3'b010, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step(3'b000, 1'b0);
            chk("b_to_early", int'(to_w[1]), 0);
        end
        step(3'b000, 1'b0);
        chk("b_to_pulse", int'(to_w[1]), 1); chk("b_to_state", int'(st_w[1]), 0);
        chk("b_to_seen", int'(seen_w[1]), 0); chk("b_to_o", int'(o_w[1]), 0);
        step(3'b000, 1'b0);
        chk("b_to_after", int'(to_w[1]), 0);
        step(3'b000, 1'b1);

        // completion on the timeout edge wins
        step(3'b010, 1'b0);
        for (int j = 0; j < 3; j++) step(3'b000, 1'b0);
        step(3'b101, 1'b0);
        chk("b_race_o", int'(o_w[1]), 1); chk("b_race_to", int'(to_w[1]), 0);
        chk("b_race_state", int'(st_w[1]), 2);
        step(3'b000, 1'b1);

        // auto re-arm and counter saturation
        pulse_reset();
        for (int j = 0; j < 12; j++) begin
            step(3'b111, 1'b0);
            chk("c_ar_o", int'(o_w[2]), (j % 2 == 0) ? 1 : 0);
            chk("c_ar_state", int'(st_w[2]), (j % 2 == 0) ? 2 : 0);
            chk("c_ar_cnt", int'(cnt_c), (j / 2 + 1 > 3) ? 3 : j / 2 + 1);
        end
        step(3'b000, 1'b1);

        // restart beats completion on the same edge
        step(3'b011, 1'b0);
        step(3'b100, 1'b1);
        chk("a_rwin_state", int'(st_w[0]), 0); chk("a_rwin_o", int'(o_w[0]), 0);
        chk("a_rwin_seen", int'(seen_w[0]), 0);

        // asynchronous reset mid-collect, then first edge behaves as IDLE
        step(3'b011, 1'b0);
        chk("a_pre_rst_seen", int'(seen_w[0]), 3);
        pulse_reset();
        step(3'b111, 1'b0);
        chk("a_post_rst_o", int'(o_w[0]), 1); chk("a_post_rst_state", int'(st_w[0]), 2);
        chk("a_post_rst_cnt", int'(cnt_a), 1);
        step(3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
